// File: rtl/pipe_control_pkg.sv
// pipe_control_pkg: ISA encodings and control codes shared by the pipeline control slice
package pipe_control_pkg;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_LOG  = 6'b000001;
  localparam logic [5:0] OP_SHF  = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000101;
  localparam logic [5:0] OP_ANDI = 6'b001001;
  localparam logic [5:0] OP_ORI  = 6'b001010;
  localparam logic [5:0] OP_XORI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b001101;
  localparam logic [5:0] OP_SW   = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b001111;
  localparam logic [5:0] OP_BNE  = 6'b010000;
  localparam logic [5:0] OP_J    = 6'b010010;
  localparam logic [2:0] FN_ADD = 3'b001;
  localparam logic [2:0] FN_AND = 3'b001;
  localparam logic [2:0] FN_OR  = 3'b010;
  localparam logic [2:0] FN_XOR = 3'b100;
  localparam logic [2:0] FN_SRL = 3'b010;
  localparam logic [2:0] FN_SLL = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;
endpackage

// File: rtl/pipe_decode.sv
// pipe_decode: combinational ID-stage decode; unknown encodings and empty slots become NOPs
module pipe_decode import pipe_control_pkg::*; #(
  parameter int RA_W = 5
) (
  input  logic            id_valid,
  input  logic [5:0]      op,
  input  logic [5:0]      func,
  input  logic [RA_W-1:0] rt,
  input  logic [RA_W-1:0] rd,
  output logic            regrt,
  output logic            aluimm,
  output logic            sext,
  output logic            shift,
  output logic            illegal,
  output logic            wreg,
  output logic            m2reg,
  output logic            wmem,
  output logic            use_rs,
  output logic            use_rt,
  output logic            is_beq,
  output logic            is_bne,
  output logic            is_j,
  output logic [2:0]      aluc,
  output logic [RA_W-1:0] wn
);
  logic r_add, r_and, r_or, r_xor, r_srl, r_sll, r_type;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_j, i_wrt, legal, v;
  logic unused_func;
  assign unused_func = ^func[5:3];
  always_comb begin
    r_add  = op == OP_ADD && func[2:0] == FN_ADD;
    r_and  = op == OP_LOG && func[2:0] == FN_AND;
    r_or   = op == OP_LOG && func[2:0] == FN_OR;
    r_xor  = op == OP_LOG && func[2:0] == FN_XOR;
    r_srl  = op == OP_SHF && func[2:0] == FN_SRL;
    r_sll  = op == OP_SHF && func[2:0] == FN_SLL;
    i_addi = op == OP_ADDI;
    i_andi = op == OP_ANDI;
    i_ori  = op == OP_ORI;
    i_xori = op == OP_XORI;
    i_lw   = op == OP_LW;
    i_sw   = op == OP_SW;
    i_beq  = op == OP_BEQ;
    i_bne  = op == OP_BNE;
    i_j    = op == OP_J;
    r_type = r_add | r_and | r_or | r_xor | r_srl | r_sll;
    i_wrt  = i_addi | i_andi | i_ori | i_xori | i_lw;
    legal  = r_type | i_wrt | i_sw | i_beq | i_bne | i_j;
    v       = id_valid & legal;
    illegal = id_valid & ~legal;
    regrt   = v & i_wrt;
    aluimm  = v & (i_wrt | i_sw);
    sext    = v & (i_addi | i_lw | i_sw | i_beq | i_bne);
    shift   = v & (r_srl | r_sll);
    m2reg   = v & i_lw;
    wmem    = v & i_sw;
    wn      = regrt ? rt : rd;
    wreg    = v & (r_type | i_wrt) & |wn;
    use_rs  = v & ~i_j;
    use_rt  = v & (r_type | i_sw | i_beq | i_bne);
    is_beq  = v & i_beq;
    is_bne  = v & i_bne;
    is_j    = v & i_j;
    aluc = !v ? ALU_ADD : (r_and | i_andi) ? ALU_AND : (r_or | i_ori) ? ALU_OR :
           (r_xor | i_xori) ? ALU_XOR : r_srl ? ALU_SRL : r_sll ? ALU_SLL :
           (i_beq | i_bne) ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/pipe_control.sv
// pipe_control: hazard detection, forwarding select, branch steering, EX/MEM/WB control registers
module pipe_control import pipe_control_pkg::*; #(
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [RA_W-1:0]  rs,
  input  logic [RA_W-1:0]  rt,
  input  logic [RA_W-1:0]  rd,
  input  logic             rsrtequ,
  output logic             regrt,
  output logic             aluimm,
  output logic             sext,
  output logic             shift,
  output logic             illegal,
  output logic             stall,
  output logic             if_flush,
  output logic [1:0]       pcsource,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             ex_wreg,
  output logic             ex_m2reg,
  output logic             ex_wmem,
  output logic [2:0]       ex_aluc,
  output logic             ex_aluimm,
  output logic             ex_shift,
  output logic [RA_W-1:0]  ex_wn,
  output logic             mem_wreg,
  output logic             mem_m2reg,
  output logic             mem_wmem,
  output logic [RA_W-1:0]  mem_wn,
  output logic             wb_wreg,
  output logic             wb_m2reg,
  output logic [RA_W-1:0]  wb_wn,
  output logic [CNT_W-1:0] stall_cnt
);
  logic wreg, m2reg, wmem, use_rs, use_rt, is_beq, is_bne, is_j;
  logic [2:0] aluc;
  logic [RA_W-1:0] wn;
  logic ex_rs, ex_rt, mem_rs, mem_rt, hazard;
  pipe_decode #(.RA_W(RA_W)) u_decode (
    .id_valid(id_valid), .op(op), .func(func), .rt(rt), .rd(rd),
    .regrt(regrt), .aluimm(aluimm), .sext(sext), .shift(shift), .illegal(illegal),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .use_rs(use_rs), .use_rt(use_rt),
    .is_beq(is_beq), .is_bne(is_bne), .is_j(is_j), .aluc(aluc), .wn(wn)
  );
  // A match needs a real write to a nonzero register that this instruction actually reads
  always_comb begin
    ex_rs  = use_rs & ex_wreg & |ex_wn & ex_wn == rs;
    ex_rt  = use_rt & ex_wreg & |ex_wn & ex_wn == rt;
    mem_rs = use_rs & mem_wreg & |mem_wn & mem_wn == rs;
    mem_rt = use_rt & mem_wreg & |mem_wn & mem_wn == rt;
    hazard = FWD_EN != 0 ? ex_m2reg & (ex_rs | ex_rt) : ex_rs | ex_rt | mem_rs | mem_rt;
    stall  = ~rst & hazard;
    fwda = FWD_EN == 0 ? FWD_RF : ex_rs ? FWD_EX : mem_rs ? (mem_m2reg ? FWD_LD : FWD_MEM) : FWD_RF;
    fwdb = FWD_EN == 0 ? FWD_RF : ex_rt ? FWD_EX : mem_rt ? (mem_m2reg ? FWD_LD : FWD_MEM) : FWD_RF;
    pcsource = stall ? PC_SEQ : is_j ? PC_JMP :
               ((is_beq & rsrtequ) | (is_bne & ~rsrtequ)) ? PC_BR : PC_SEQ;
    if_flush = pcsource != PC_SEQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {ex_wreg, ex_m2reg, ex_wmem, ex_aluc, ex_aluimm, ex_shift, ex_wn} <= '0;
      {mem_wreg, mem_m2reg, mem_wmem, mem_wn} <= '0;
      {wb_wreg, wb_m2reg, wb_wn} <= '0;
      stall_cnt <= '0;
    end else begin
      ex_wreg   <= wreg & ~stall;
      ex_m2reg  <= m2reg & ~stall;
      ex_wmem   <= wmem & ~stall;
      ex_aluc   <= stall ? ALU_ADD : aluc;
      ex_aluimm <= aluimm & ~stall;
      ex_shift  <= shift & ~stall;
      ex_wn     <= stall ? '0 : wn;
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      mem_wmem  <= ex_wmem;
      mem_wn    <= ex_wn;
      wb_wreg   <= mem_wreg;
      wb_m2reg  <= mem_m2reg;
      wb_wn     <= mem_wn;
      if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter RA_W, default 5: register-index width.
REQ-002 Parameter FWD_EN, default 1: 1 = forwarding with load-use stall; 0 = no forwarding, stall on every RAW hazard.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port id_valid, input, 1: the ID stage holds a real instruction.
REQ-007 Ports op and func, input, 6 each: ID instruction opcode and function fields.
REQ-008 Ports rs, rt and rd, input, RA_W each: ID register indices.
REQ-009 Port rsrtequ, input, 1: the forwarded ID operands are equal.
REQ-010 Ports regrt, aluimm, sext, shift and illegal, output, 1 each: ID decode, combinational.
REQ-011 Ports stall and if_flush, output, 1 each: stall holds the PC and IF/ID; if_flush squashes IF/ID.
REQ-012 Port pcsource, output, 2: 00 = pc+4; 01 = branch target; 10 = jump target.
REQ-013 Ports fwda and fwdb, output, 2 each: 00 = register file; 01 = EX ALU result; 10 = MEM ALU result; 11 = MEM load data.
REQ-014 Ports ex_wreg, ex_m2reg, ex_wmem, ex_aluc[2:0], ex_aluimm, ex_shift and ex_wn[RA_W], output: registered EX controls.
REQ-015 Ports mem_wreg, mem_m2reg, mem_wmem and mem_wn, output: registered MEM controls.
REQ-016 Ports wb_wreg, wb_m2reg and wb_wn, output: registered WB controls.
REQ-017 Port stall_cnt, output, CNT_W: count of stall cycles.

Function
REQ-018 Decode SHALL use this ISA (op/func[2:0]):
- add 000000/001; and 000001/001; or 000001/010; xor 000001/100.
- srl 000010/010; sll 000010/011.
- addi 000101; andi 001001; ori 001010; xori 001100.
- lw 001101; sw 001110; beq 001111; bne 010000; j 010010.
REQ-019 aluc SHALL be: add/addi/lw/sw 000; and/andi 001; or/ori 010; xor/xori 011; srl 100; sll 101; beq/bne 110.
REQ-020 An unlisted op/func, or id_valid=0, SHALL decode as a NOP: all write enables 0, aluc 000, pcsource 00; illegal=1 only for the unlisted encoding with id_valid=1.
REQ-021 Write-register number SHALL be rt when regrt=1, else rd; wreg for index 0 SHALL be forced to 0.
REQ-022 Source use: rs is used by all except j; rt is used by R-type, sw, beq and bne.
REQ-023 FWD_EN=1 hazard rule:
- stall=1 when ex_wreg & ex_m2reg & ex_wn≠0 & ex_wn matches a used source.
- Otherwise fwdX = 01 on an EX match, else 10/11 on a MEM match (11 if mem_m2reg), else 00.
- EX match has priority over MEM match.
REQ-024 FWD_EN=0 hazard rule: stall=1 on any used-source match with EX or MEM writeback (index≠0); fwda=fwdb=00 always.
REQ-025 While stall=1: EX registers SHALL load a bubble (all enables 0); MEM and WB advance normally.
REQ-026 While stall=1: pcsource=00 and if_flush=0.
REQ-027 Without stall: beq with rsrtequ=1, or bne with rsrtequ=0 → pcsource=01, if_flush=1; j → pcsource=10, if_flush=1.
REQ-028 Pipeline latency SHALL be exactly one cycle per stage (ID→EX→MEM→WB).
REQ-029 stall_cnt SHALL increment each cycle stall=1 and saturate at all-ones.

Reset
REQ-030 rst=1 at a rising edge SHALL clear all EX/MEM/WB registers and stall_cnt to 0; this overrides stall.
REQ-031 During reset, combinational outputs SHALL follow the inputs, except that stall is forced to 0.
REQ-032 Reset asserted mid-stall SHALL leave no pending bubble or branch once deasserted.

Structure
REQ-033 A shared package SHALL hold the opcode/func constants, aluc codes, pcsource codes and fwd codes.
REQ-034 A sub-module pipe_decode SHALL hold the purely combinational decode (REQ-018 to REQ-022); pipe_control SHALL hold hazard, forwarding, stage registers and counter.

Verification
REQ-035 lw r2 then add r3,r2,r4: exactly one stall cycle; stall_cnt=1; next cycle fwda=11.
REQ-036 add r2 then add r5,r2,r2: no stall; fwda=fwdb=01. With FWD_EN=0: two stall cycles and fwd=00.
REQ-037 beq with rsrtequ=1 → pcsource=01, if_flush=1; bne with rsrtequ=1 → pcsource=00.
REQ-038 j → pcsource=10, if_flush=1, ex_wreg=0; op=111111 → illegal=1, no writes.
REQ-039 add r0,r1,r1 then add r4,r0,r0 → no forwarding (fwd=00), wb_wreg=0.
REQ-040 rst during a stall → all stage outputs 0 next edge, stall_cnt=0; 2^CNT_W+3 stall cycles → stall_cnt stays all-ones.
